// File: rtl/gray_convert.sv
// rtl/gray_convert.sv - two-stage RGB-to-grayscale converter with per-frame mode and frame counting
module gray_convert #(
  parameter int CH_W   = 8,
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        mode,
  output logic              in_rd_en,
  input  logic              in_empty,
  input  logic [3*CH_W-1:0] in_dout,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic [CH_W-1:0]   out_din,
  output logic              frame_done
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int SUM_W = CH_W + 2;
  localparam int ACC_W = CH_W + 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  typedef enum logic [1:0] {
    MODE_AVG  = 2'd0,
    MODE_LUMA = 2'd1,
    MODE_MAX  = 2'd2
  } mode_e;

  logic [CH_W-1:0]  r, g, b;
  logic             advance;
  mode_e            cur_mode;
  logic [SUM_W-1:0] sum_d;
  logic [ACC_W-1:0] acc_d;
  logic [CH_W-1:0]  max_rg, max_d;
  logic [CH_W-1:0]  gray_d;

  mode_e            mode_q;
  logic [CNT_W-1:0] in_count_q, out_count_q;
  logic             s1_valid_q, s2_valid_q;
  mode_e            s1_mode_q;
  logic [SUM_W-1:0] s1_sum_q;
  logic [ACC_W-1:0] s1_acc_q;
  logic [CH_W-1:0]  s1_max_q;
  logic [CH_W-1:0]  s2_data_q;

  assign r = in_dout[3*CH_W-1:2*CH_W];
  assign g = in_dout[2*CH_W-1:CH_W];
  assign b = in_dout[CH_W-1:0];

  // Only a valid S2 pixel facing a full FIFO can block the pipe; bubbles never do.
  assign advance    = !(s2_valid_q && out_full);
  assign in_rd_en   = reset && !in_empty && advance;
  assign out_wr_en  = reset && s2_valid_q && !out_full;
  assign out_din    = reset ? s2_data_q : '0;
  assign frame_done = out_wr_en && (out_count_q == LAST_IDX);

  always_comb begin
    sum_d  = SUM_W'(r) + SUM_W'(g) + SUM_W'(b);
    acc_d  = ACC_W'(r) * ACC_W'(77) + ACC_W'(g) * ACC_W'(150) + ACC_W'(b) * ACC_W'(29);
    max_rg = (r > g) ? r : g;
    max_d  = (max_rg > b) ? max_rg : b;
    // The first pop of a frame samples the live input; mode 3 folds into average here.
    if (in_count_q == '0) begin
      cur_mode = (mode == 2'd3) ? MODE_AVG : mode_e'(mode);
    end else begin
      cur_mode = mode_q;
    end
  end

  always_comb begin
    gray_d = '0;
    case (s1_mode_q)
      MODE_LUMA: gray_d = CH_W'(s1_acc_q >> 8);
      MODE_MAX:  gray_d = s1_max_q;
      default:   gray_d = CH_W'(s1_sum_q / SUM_W'(3));
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_q      <= MODE_AVG;
      in_count_q  <= '0;
      out_count_q <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_AVG;
      s1_sum_q    <= '0;
      s1_acc_q    <= '0;
      s1_max_q    <= '0;
      s2_data_q   <= '0;
    end else begin
      if (advance) begin
        s1_valid_q <= in_rd_en;
        if (in_rd_en) begin
          s1_mode_q <= cur_mode;
          s1_sum_q  <= sum_d;
          s1_acc_q  <= acc_d;
          s1_max_q  <= max_d;
        end
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= gray_d;
        end
      end
      if (in_rd_en) begin
        mode_q     <= cur_mode;
        in_count_q <= (in_count_q == LAST_IDX) ? '0 : in_count_q + CNT_W'(1);
      end
      if (out_wr_en) begin
        out_count_q <= (out_count_q == LAST_IDX) ? '0 : out_count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_convert.sv
// tb/tb_gray_convert.sv - scoreboard bench for gray_convert with a 4x2 frame
module tb_gray_convert;
  localparam int CH_W   = 8;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 2;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        in_rd_en;
  logic        in_empty = 1'b1;
  logic [23:0] in_dout = 24'h0;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic [7:0]  out_din;
  logic        frame_done;

  always #5 clock = ~clock;

  gray_convert #(.CH_W(CH_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .out_wr_en  (out_wr_en),
    .out_full   (out_full),
    .out_din    (out_din),
    .frame_done (frame_done)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] in_q[$];
  logic [7:0]  exp_q[$];
  int          popcyc_q[$];
  bit          latok_q[$];

  bit          rst_v = 1'b0, full_v = 1'b0, empty_v = 1'b0, lat_en = 1'b1;
  bit          stall_chk = 1'b0, nostall_chk = 1'b0;
  logic [1:0]  mode_v = 2'd0;
  logic [1:0]  mlat_m = 2'd0;
  int          cyc = 0, pops_m = 0, wr_m = 0, fd_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [7:0] model_gray(input logic [1:0] m, input logic [23:0] p);
    int r, g, b, v;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    case (m)
      2'd1:    v = (77 * r + 150 * g + 29 * b) / 256;
      2'd2:    v = (r >= g && r >= b) ? r : ((g >= b) ? g : b);
      default: v = (r + g + b) / 3;
    endcase
    return v[7:0];
  endfunction

  task automatic step();
    logic [1:0]  em;
    logic [23:0] px;
    logic [7:0]  e;
    int          pc;
    bit          lo;
    @(posedge clock);
    #2;
    reset    = rst_v;
    mode     = mode_v;
    out_full = full_v;
    in_empty = empty_v || (in_q.size() == 0);
    in_dout  = (in_q.size() != 0) ? in_q[0] : 24'h0;
    #1;
    cyc++;
    if (!rst_v) begin
      check("rst_rd_en", 32'(in_rd_en), 0);
      check("rst_wr_en", 32'(out_wr_en), 0);
      check("rst_din", 32'(out_din), 0);
      check("rst_fd", 32'(frame_done), 0);
      exp_q.delete();
      popcyc_q.delete();
      latok_q.delete();
      pops_m = 0;
      wr_m   = 0;
      mlat_m = 2'd0;
    end else begin
      if (stall_chk) begin
        check("stall_rd_en", 32'(in_rd_en), 0);
        check("stall_wr_en", 32'(out_wr_en), 0);
      end
      if (nostall_chk) check("bubble_full_rd_en", 32'(in_rd_en), 1);
      if (in_rd_en) begin
        em = (pops_m == 0) ? mode_v : mlat_m;
        if (pops_m == 0) mlat_m = mode_v;
        px = in_q.pop_front();
        exp_q.push_back(model_gray(em, px));
        popcyc_q.push_back(cyc);
        latok_q.push_back(lat_en);
        pops_m = (pops_m == NPIX - 1) ? 0 : pops_m + 1;
      end
      if (out_wr_en) begin
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e  = exp_q.pop_front();
          pc = popcyc_q.pop_front();
          lo = latok_q.pop_front();
          check("out_din", 32'(out_din), 32'(e));
          check("frame_done", 32'(frame_done), 32'(wr_m == NPIX - 1));
          if (lo) check("latency", 32'(cyc - pc), 2);
          if (frame_done) fd_cnt++;
          wr_m = (wr_m == NPIX - 1) ? 0 : wr_m + 1;
        end
      end else begin
        check("fd_idle", 32'(frame_done), 0);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_rand(input int n);
    logic [23:0] rv;
    repeat (n) begin
      rv = 24'($urandom());
      in_q.push_back(rv);
    end
  endtask

  task automatic run_frame(input logic [1:0] m_first, input logic [1:0] m_mid,
                           input int stall_at, input int empty_at, input bit full_first);
    mode_v = m_first;
    lat_en = (stall_at < 0);
    for (int k = 0; k < 200 && in_q.size() != 0; k++) begin
      stall_chk   = (stall_at >= 0) && (k >= stall_at) && (k < stall_at + 5);
      nostall_chk = full_first && (k == 0);
      full_v      = stall_chk || nostall_chk;
      empty_v     = (k == empty_at);
      if (k == 3) mode_v = m_mid;
      step();
    end
    full_v      = 1'b0;
    stall_chk   = 1'b0;
    nostall_chk = 1'b0;
    empty_v     = 1'b0;
    lat_en      = 1'b1;
    check("frame_fed", 32'(in_q.size()), 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst_v = 1'b0;
    idle(3);
    rst_v = 1'b1;

    // Average frame, then luma frame back-to-back: 16 pops and writes on consecutive cycles.
    in_q.push_back(24'h306090);
    in_q.push_back(24'h010000);
    push_rand(6);
    run_frame(2'd0, 2'd1, -1, -1, 1'b0);
    in_q.push_back(24'hFFFFFF);
    in_q.push_back(24'h640000);
    in_q.push_back(24'h00FF00);
    push_rand(5);
    run_frame(2'd1, 2'd2, -1, -1, 1'b0);

    // One idle cycle lines up the last write of the frame with the first pop of the next.
    idle(1);
    in_q.push_back(24'h12A033);
    push_rand(7);
    run_frame(2'd2, 2'd0, 3, -1, 1'b0);
    drain();

    idle(3);
    in_q.push_back(24'h306090);
    push_rand(7);
    run_frame(2'd3, 2'd1, -1, 2, 1'b1);
    drain();

    // Reset with both stages holding pixels; remaining pixels form a fresh frame.
    push_rand(6);
    mode_v = 2'd1;
    idle(4);
    rst_v = 1'b0;
    idle(1);
    rst_v = 1'b1;
    push_rand(6);
    run_frame(2'd2, 2'd0, -1, -1, 1'b0);
    drain();
    idle(2);

    check("fd_count", 32'(fd_cnt), 5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gray_convert.md
# gray_convert

Parametrised RGB-to-grayscale converter for the image pipeline, placed between the RGB input FIFO and the single-channel grayscale FIFO feeding the downstream filter stages. It generalises the single-mode, two-cycles-per-pixel converter in three ways:
- channel width is a parameter;
- three conversion modes are selectable per frame;
- a two-stage pipeline sustains one pixel per clock under FIFO back-pressure.

It also counts pixels and flags end of frame.

## Interface
Parameters:
- CH_W, 8, bits per colour channel and per grayscale output
- WIDTH, 720, pixels per line
- HEIGHT, 540, lines per frame

Ports:
- clock  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (sampled on clock; 0 = reset)
- mode  input  2  conversion select: 0 average, 1 luma, 2 max, 3 treated as average
- in_rd_en  output  1  pop strobe to first-word-fall-through RGB FIFO
- in_empty  input  1  RGB FIFO empty
- in_dout  input  3*CH_W  pixel {R[3*CH_W-1:2*CH_W], G[2*CH_W-1:CH_W], B[CH_W-1:0]}, valid when in_empty=0
- out_wr_en  output  1  push strobe to grayscale FIFO
- out_full  input  1  grayscale FIFO full
- out_din  output  CH_W  grayscale pixel
- frame_done  output  1  one-cycle pulse with the write of the last pixel of a frame

## Operation
Datapath has two pipeline stages, S1 and S2, each with a valid bit.
- advance = !(s2_valid && out_full).
- in_rd_en = !in_empty && advance (combinational). On a pop, S1 captures the partial result and s1_valid=1. If advance=1 and no pop, s1_valid=0.
- When advance=1, S2 captures S1's final result and s2_valid=s1_valid.
- When advance=0, S1 and S2 hold their contents.
- out_wr_en = s2_valid && !out_full; out_din = S2 data. While out_wr_en=0, out_din holds the S2 register value.

Arithmetic (unsigned, no intermediate truncation):
- Average: sum = R+G+B in CH_W+2 bits, computed in S1; gray = floor(sum/3) in S2.
- Luma: acc = 77*R + 150*G + 29*B in CH_W+8 bits; gray = acc>>8 (truncate, no rounding). Weights sum to 256, so the result never exceeds 2^CH_W-1. Products may be split across S1 and S2.
- Max: gray = max(R,G,B).
- The mode travels with each pixel through the pipeline.

Mode latch:
- The mode input is sampled on the pop of the first pixel of a frame (in_count==0) and held for every pixel popped in that frame.
- Changes to mode at any other time are ignored until the next frame's first pop.

Counters:
- in_count counts pops, 0..WIDTH*HEIGHT-1, and wraps to 0 after the last pixel.
- out_count counts writes over the same range and wraps the same way.
- frame_done = out_wr_en && out_count==WIDTH*HEIGHT-1.
- Counter width is $clog2(WIDTH*HEIGHT).

Reset (reset=0 at a rising edge):
- s1_valid, s2_valid, in_count and out_count cleared; latched mode = 0; S2 data = 0.
- In-flight pixels are discarded, not written.
- The next pop after reset deasserts is treated as the first pixel of a frame.
- While reset=0: in_rd_en=0, out_wr_en=0, frame_done=0, out_din=0.

## Timing
- Latency: pixel popped at rising edge N is presented with out_wr_en=1 in cycle N+2, if out_full=0 then.
- Throughput: one pixel per clock while !in_empty && !out_full.
- Back-pressure:
  - out_full=1 with s2_valid=1 stalls both stages and forces in_rd_en=0 in the same cycle.
  - out_full=1 with s2_valid=0 does not stall; bubbles are squeezed out.
- Stall release: the cycle out_full drops, the held S2 pixel is written and a new pop may occur in that same cycle.
- Empty: in_empty=1 inserts a bubble (s1_valid=0). No output is written for bubbles.
- Simultaneous end of frame and new frame: the last-pixel write (frame_done=1) and the pop of the next frame's first pixel (mode sampled) occur in the same cycle without interference.
- No combinational path from in_dout to any output.

## Test plan
- Average, CH_W=8: in_dout=0x306090 -> out_din=0x60 two cycles after the pop. Input 0x010000 -> 0x00 (floor).
- Luma: 0xFFFFFF -> 0xFF; 0x640000 -> 0x1E (7700>>8); 0x00FF00 -> 0x95 (38250>>8).
- Max: 0x12A033 -> 0xA0. Mode 3 with 0x306090 -> 0x60.
- Streaming and back-pressure:
  - 16 pixels back-to-back with out_full=0 -> 16 writes on consecutive cycles, in order.
  - Hold out_full=1 for 5 cycles mid-stream -> in_rd_en=0 during those cycles, no pixel lost or duplicated, order preserved.
- Frame handling, WIDTH=4, HEIGHT=2:
  - Change mode mid-frame -> no effect until pixel 8.
  - frame_done pulses exactly on the 8th and 16th writes.
  - Mode sampled at pop 8 applies to pixels 8-15.
- Reset mid-stream: drive reset=0 for 1 cycle with both stages valid -> no further writes from those pixels, outputs 0 during reset. The next popped pixel starts a new frame (frame_done after WIDTH*HEIGHT further writes).
